// File: rtl/sqrt_result_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_pkg: shared types and helpers for the square-root result buffer.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sqrt_pkg;

    localparam int SQRT_DATAWIDTH = 8;

    typedef struct packed {
        logic [SQRT_DATAWIDTH-1:0] root;
        logic [SQRT_DATAWIDTH-1:0] rem;
    } sqrt_result_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_result_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_result_buffer_if: request, producer-result and consumer handshakes. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sqrt_result_buffer_if
    import sqrt_pkg::*;
#(
    parameter int DATAWIDTH = SQRT_DATAWIDTH
);

    logic                 s_req_valid;
    logic                 s_req_ready;
    logic                 o_issue;
    logic                 i_valid;
    logic [DATAWIDTH-1:0] i_root;
    logic [DATAWIDTH-1:0] i_rem;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATAWIDTH-1:0] m_root;
    logic [DATAWIDTH-1:0] m_rem;

    modport slave (
        input  s_req_valid,
        input  i_valid,
        input  i_root,
        input  i_rem,
        input  m_ready,
        output s_req_ready,
        output o_issue,
        output m_valid,
        output m_root,
        output m_rem
    );

    modport master (
        output s_req_valid,
        output i_valid,
        output i_root,
        output i_rem,
        output m_ready,
        input  s_req_ready,
        input  o_issue,
        input  m_valid,
        input  m_root,
        input  m_rem
    );

endinterface
`default_nettype wire

// File: rtl/sqrt_result_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_result_fifo_mem: DEPTH x ENTRY_W register array, one write port,    |
// | asynchronous read. Contents are not cleared by reset.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module sqrt_result_fifo_mem #(
    parameter int ENTRY_W = 16,
    parameter int DEPTH   = 4
)(
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  logic [ENTRY_W-1:0]       i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output logic [ENTRY_W-1:0]       o_rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/sqrt_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_result_buffer: credit-gated result buffer behind the square-root    |
// | pipeline. SQRT_RESULT_BUFFER_REM_EN stores the remainder too. Rev 1.0    |
// +--------------------------------------------------------------------------+
module sqrt_result_buffer
    import sqrt_pkg::*;
#(
    parameter int DATAWIDTH = SQRT_DATAWIDTH,
    parameter int DEPTH     = 4
)(
    input  logic                        clk,
    input  logic                        rst,
    sqrt_result_buffer_if.slave         bus,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic [cnt_width(DEPTH)-1:0] o_credits,
    output logic                        o_overflow
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
`ifdef SQRT_RESULT_BUFFER_REM_EN
    localparam int            ENTRY_W = 2 * DATAWIDTH;
`else
    localparam int            ENTRY_W = DATAWIDTH;
`endif

    logic [CW-1:0]      r_credits;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_credits_nxt;
    logic               r_req_ready;
    logic               r_overflow;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic               w_issue;
    logic               w_pop;
    logic               w_push;
    logic               w_valid;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;

    assign w_valid = (r_count != '0);
    assign w_issue = bus.s_req_valid & r_req_ready;
    assign w_pop   = w_valid & bus.m_ready;
    // A full buffer still accepts a result when the head leaves the same cycle.
    assign w_push  = bus.i_valid & ((r_count < c_depth) | w_pop);

    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_issue, w_pop})
            2'b10:   w_credits_nxt = r_credits - CW'(1);
            2'b01:   w_credits_nxt = r_credits + CW'(1);
            default: w_credits_nxt = r_credits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credits   <= c_depth;
            r_req_ready <= 1'b1;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_credits   <= w_credits_nxt;
            // Ready is registered from the next credit value so it tracks credits exactly.
            r_req_ready <= (w_credits_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.i_valid & ~w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SQRT_RESULT_BUFFER_REM_EN
    assign w_wr_data = {bus.i_root, bus.i_rem};
    assign bus.m_rem = w_valid ? w_rd_data[DATAWIDTH-1:0] : '0;
`else
    logic w_unused_rem;
    assign w_unused_rem = ^bus.i_rem;
    assign w_wr_data    = bus.i_root;
    assign bus.m_rem    = '0;
`endif

    sqrt_result_fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.s_req_ready = r_req_ready;
    assign bus.o_issue     = w_issue;
    assign bus.m_valid     = w_valid;
    assign bus.m_root      = w_valid ? w_rd_data[ENTRY_W-1 -: DATAWIDTH] : '0;
    assign o_count         = r_count;
    assign o_credits       = r_credits;
    assign o_overflow      = r_overflow;

endmodule
`default_nettype wire

// File: doc/sqrt_result_buffer.md
# sqrt_result_buffer

Credit-managed result buffer that sits directly downstream of the pipelined integer square-root unit. It gates new requests into the root pipeline so that results in flight never exceed free buffer space. It captures each `{root, rem}` result as it exits the pipeline, which has no backpressure. It presents the results to a consumer over a ready/valid handshake.

## Interface
- `DATAWIDTH`, 8: radicand/root/remainder width; must match the producer.
- `DEPTH`, 4: result entries; power of two, ≥2.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `s_req_valid` in 1: requester has a radicand to issue.
- `s_req_ready` out 1: a credit is available (`credits != 0`).
- `o_issue` out 1: `s_req_valid & s_req_ready`, combinational; drives the producer's `i_valid`.
- `i_valid` in 1: result strobe from the producer's `o_valid`.
- `i_root` in DATAWIDTH: result root.
- `i_rem` in DATAWIDTH: result remainder.
- `m_valid` out 1: buffer not empty.
- `m_ready` in 1: consumer accepts the head entry.
- `m_root` out DATAWIDTH: head root; 0 when `m_valid`=0.
- `m_rem` out DATAWIDTH: head remainder; 0 when `m_valid`=0.
- `o_count` out $clog2(DEPTH+1): occupied entries.
- `o_credits` out $clog2(DEPTH+1): free credits.
- `o_overflow` out 1: sticky protocol-error flag.

## Operation
- **Credit counter:**
  - Reset value is DEPTH.
  - Decrements on `o_issue`; increments on pop (`m_valid & m_ready`).
  - Both in the same cycle: unchanged.
  - Never wraps: `s_req_ready`=0 at 0 credits, and a pop cannot occur with `credits==DEPTH`.
- **Push:**
  - Every `i_valid` cycle writes `{i_root, i_rem}` at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
  - A push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- **Overflow:** `i_valid` while full with no simultaneous pop:
  - the data is dropped and no pointer moves;
  - `o_overflow` is set and held until reset.
  - This is unreachable when the credit rule is obeyed.
- **Pop:**
  - `m_valid & m_ready` advances `rd_ptr` modulo DEPTH.
  - `m_ready` while empty is ignored.
- **Count:** `o_count` is +1 on push-only, −1 on pop-only, unchanged on push+pop or when idle.
- **Invariant (asserted in simulation):** `o_count + in_flight + o_credits == DEPTH`, where `in_flight` is issued results not yet pushed.
- **Reset values:**
  - `o_count`=0, `o_credits`=DEPTH, `o_overflow`=0.
  - `m_valid`=0, `m_root`=0, `m_rem`=0, `s_req_ready`=1.
  - Pointers are 0.
  - Storage is not cleared.
- **Reset mid-operation:** the producer shares `rst`, so in-flight results are discarded with it. `i_valid` in the first cycle after `rst` rises is accepted normally.

## Timing
- **Push to visible:** a push in cycle t makes `m_valid`=1 in cycle t+1, with data valid the same cycle. There is no combinational `i_*`→`m_*` path.
- **Pop, next entry:** after a pop in cycle t, the next entry is on `m_*` in cycle t+1.
- **Pop, credit return:** a pop in cycle t returns the credit in cycle t+1, so `s_req_ready` can rise at t+1.
- **Issue rate:** one issue per cycle is sustainable when the consumer holds `m_ready`=1.
- **Ready path:** `s_req_ready` is a registered compare. `o_issue` is the only combinational output.
- **Consumer rule:** the consumer may stall indefinitely; `m_root`/`m_rem` hold stable while `m_valid & !m_ready`.

## Configuration
- **Macro:** `SQRT_RESULT_BUFFER_REM_EN`.
- **Defined:**
  - the remainder is stored, with entry width 2·DATAWIDTH;
  - `m_rem` carries the head remainder.
- **Undefined:**
  - `i_rem` is ignored and entry width is DATAWIDTH;
  - `m_rem` is tied to 0.
- Credit, count and overflow behaviour are identical in both builds.

## Structure
- **Package `sqrt_pkg`:**
  - `SQRT_DATAWIDTH` default constant;
  - `sqrt_result_t` packed struct `{root, rem}`;
  - `cnt_width(depth)` function returning $clog2(depth+1).
- **Sub-module `sqrt_result_fifo_mem`:**
  - DEPTH×entry register array;
  - write port with write pointer;
  - asynchronous read at the read pointer.
- **Top level keeps:** the credit counter, count, overflow logic and output zeroing.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → `o_credits`=4, `o_count`=0, `m_valid`=0, `s_req_ready`=1, `o_overflow`=0.
- **Single result:** issue rad=49; inject `i_valid` with root=7, rem=0, `m_ready`=0 → `m_valid` the next cycle with `m_root`=7, `m_rem`=0; `o_credits`=3 until the pop, 4 the cycle after.
- **Fill:**
  - 4 issues with `m_ready`=0 → `s_req_ready`=0 and `o_issue`=0 with `s_req_valid` held.
  - After 4 results, `o_count`=4.
  - One pop → `s_req_ready`=1 the next cycle.
- **Streaming:** `m_ready`=1, 16 back-to-back issues of rad 0..15 → 16 results in order (e.g. rad 15: root 3, rem 6), `o_count` ≤1, no bubbles.
- **Overflow:** force `i_valid` (root=9) while `o_count`=4 and `m_ready`=0 → entry dropped, `o_overflow`=1 and sticky, existing 4 entries intact.
- **Simultaneous events:** `i_valid` and pop while full → `o_count` stays 4, the new entry lands last, no overflow.
